// File: rtl/encoder_pkg.sv
// Shared types and helpers for the clocked 4-to-2 active-low priority encoder.
package encoder_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2,
        RELEASE  = 2'd3
    } enc_state_t;

    // All request lines released (active-low, so all ones).
    localparam logic [3:0] LINES_IDLE = 4'b1111;

    // Priority code of an active-low pattern: Q[3] wins and maps to 00, Q[0] maps to 11.
    function automatic logic [1:0] prio_encode(logic [3:0] pat);
        logic [1:0] code;
        if (!pat[3]) begin
            code = 2'b00;
        end else if (!pat[2]) begin
            code = 2'b01;
        end else if (!pat[1]) begin
            code = 2'b10;
        end else begin
            code = 2'b11;
        end
        return code;
    endfunction

    // True when more than one line is low in the pattern.
    function automatic logic multi_low(logic [3:0] pat);
        logic [2:0] zeros;
        zeros = 3'd0;
        for (int i = 0; i < 4; i++) begin
            zeros = zeros + {2'b00, ~pat[i]};
        end
        return (zeros > 3'd1);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous active-low lines; resets to all-ones (released).
module sync_2ff #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta_r;
    logic [W-1:0] sync_r;

    // Two-stage capture of the asynchronous lines; reset parks both stages at released.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_r <= {W{1'b1}};
            sync_r <= {W{1'b1}};
        end else begin
            meta_r <= d;
            sync_r <= meta_r;
        end
    end

    assign q = sync_r;

endmodule

// File: rtl/encoder_4x2_sync.sv
// Clocked 4-to-2 priority encoder: synchronises and debounces four active-low request
// lines, encodes the winning line to {A,B} and presents it on a valid/ready handshake.
module encoder_4x2_sync
    import encoder_pkg::*;
#(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] Q,
    input  logic       E,
    output logic       A,
    output logic       B,
    output logic       valid,
    input  logic       ready,
    output logic       multi
);

    localparam int CNT_W = $clog2(STABLE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

    if (STABLE_CYCLES < 2 || STABLE_CYCLES > 255) begin : g_bad_stable_cycles
        $error("encoder_4x2_sync: STABLE_CYCLES must be within 2..255");
    end

    logic [3:0]       q_s;
    logic [1:0]       code_s;
    logic             multi_s;

    enc_state_t       state_r;
    logic [3:0]       pat_r;
    logic [CNT_W-1:0] cnt_r;
    logic             a_r;
    logic             b_r;
    logic             valid_r;
    logic             multi_r;

    sync_2ff #(
        .W (4)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (Q),
        .q   (q_s)
    );

    assign code_s  = prio_encode(pat_r);
    assign multi_s = multi_low(pat_r);

    // Capture / debounce / hold / release sequencer with registered code outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            pat_r   <= LINES_IDLE;
            cnt_r   <= {CNT_W{1'b0}};
            a_r     <= 1'b0;
            b_r     <= 1'b0;
            valid_r <= 1'b0;
            multi_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (!E && (q_s != LINES_IDLE)) begin
                        pat_r   <= q_s;
                        cnt_r   <= CNT_W'(1);
                        state_r <= DEBOUNCE;
                    end
                end
                DEBOUNCE: begin
                    // A changed pattern beats a completing count on the same edge.
                    if (E || (q_s != pat_r)) begin
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= IDLE;
                    end else if (cnt_r == CNT_LAST) begin
                        a_r     <= code_s[1];
                        b_r     <= code_s[0];
                        multi_r <= multi_s;
                        valid_r <= 1'b1;
                        cnt_r   <= {CNT_W{1'b0}};
                        state_r <= HOLD;
                    end else begin
                        cnt_r   <= cnt_r + CNT_W'(1);
                    end
                end
                HOLD: begin
                    // Lines and enable are ignored here; only the handshake moves on.
                    if (valid_r && ready) begin
                        valid_r <= 1'b0;
                        state_r <= RELEASE;
                    end
                end
                RELEASE: begin
                    // One code per press: wait for every line to be released.
                    if (q_s == LINES_IDLE) begin
                        state_r <= IDLE;
                    end
                end
                default: begin
                    valid_r <= 1'b0;
                    cnt_r   <= {CNT_W{1'b0}};
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign A     = a_r;
    assign B     = b_r;
    assign valid = valid_r;
    assign multi = multi_r;

endmodule

// File: tb/tb_encoder_4x2_sync.sv
// Directed, table-driven bench for encoder_4x2_sync at the default STABLE_CYCLES=4.
module tb_encoder_4x2_sync;

    logic       clk_s;
    logic       rst_s;
    logic [3:0] q_s;
    logic       e_s;
    logic       a_s;
    logic       b_s;
    logic       valid_s;
    logic       ready_s;
    logic       multi_s;

    int n_cmp;
    int n_fail;

    typedef struct packed {
        logic [3:0] q;
        logic [1:0] code;
        logic       multi;
    } vec_t;

    vec_t vecs [8];

    encoder_4x2_sync #(
        .STABLE_CYCLES (4)
    ) dut (
        .clk   (clk_s),
        .rst   (rst_s),
        .Q     (q_s),
        .E     (e_s),
        .A     (a_s),
        .B     (b_s),
        .valid (valid_s),
        .ready (ready_s),
        .multi (multi_s)
    );

    initial clk_s = 1'b0;
    always #5 clk_s = ~clk_s;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance one rising edge and land on the following falling edge.
    task automatic step();
        @(posedge clk_s);
        @(negedge clk_s);
    endtask

    // Edges until valid is seen high (0 when the bound expires).
    task automatic wait_valid(input int max_edges, output int n);
        n = 0;
        for (int i = 1; i <= max_edges; i++) begin
            step();
            if (valid_s) begin
                n = i;
                break;
            end
        end
    endtask

    // Count valid-high samples over a window.
    task automatic count_valid(input int cycles, output int cnt);
        cnt = 0;
        for (int i = 0; i < cycles; i++) begin
            step();
            if (valid_s) cnt++;
        end
    endtask

    task automatic release_lines();
        q_s = 4'b1111;
        e_s = 1'b0;
        repeat (5) step();
    endtask

    initial begin
        int n;
        int cnt;
        int bad;

        n_cmp  = 0;
        n_fail = 0;

        vecs[0] = '{q: 4'b0111, code: 2'b00, multi: 1'b0};
        vecs[1] = '{q: 4'b1011, code: 2'b01, multi: 1'b0};
        vecs[2] = '{q: 4'b1101, code: 2'b10, multi: 1'b0};
        vecs[3] = '{q: 4'b1110, code: 2'b11, multi: 1'b0};
        vecs[4] = '{q: 4'b1010, code: 2'b01, multi: 1'b1};
        vecs[5] = '{q: 4'b0000, code: 2'b00, multi: 1'b1};
        vecs[6] = '{q: 4'b1100, code: 2'b10, multi: 1'b1};
        vecs[7] = '{q: 4'b0110, code: 2'b00, multi: 1'b1};

        rst_s   = 1'b1;
        q_s     = 4'b1111;
        e_s     = 1'b0;
        ready_s = 1'b0;
        repeat (2) @(negedge clk_s);
        check("reset_valid", int'(valid_s), 0);
        check("reset_ab", int'({a_s, b_s}), 0);
        check("reset_multi", int'(multi_s), 0);
        rst_s = 1'b0;
        repeat (2) step();

        // Table: each pattern held with ready=1; valid after edge 6, one-cycle pulse.
        for (int v = 0; v < 8; v++) begin
            q_s     = vecs[v].q;
            e_s     = 1'b0;
            ready_s = 1'b1;
            wait_valid(12, n);
            check($sformatf("v%0d_latency", v), n, 6);
            check($sformatf("v%0d_ab", v), int'({a_s, b_s}), int'(vecs[v].code));
            check($sformatf("v%0d_multi", v), int'(multi_s), int'(vecs[v].multi));
            step();
            check($sformatf("v%0d_drop", v), int'(valid_s), 0);
            count_valid(10, cnt);
            check($sformatf("v%0d_no_repeat", v), cnt, 0);
            release_lines();
        end

        // Bounce: 2 cycles low, 1 released, then stable; valid 6 edges after final start.
        ready_s = 1'b1;
        q_s = 4'b1110;
        repeat (2) step();
        q_s = 4'b1111;
        step();
        q_s = 4'b1110;
        wait_valid(12, n);
        check("bounce_latency", n, 6);
        check("bounce_ab", int'({a_s, b_s}), 3);
        count_valid(10, cnt);
        check("bounce_single", cnt, 0);
        release_lines();

        // Glitch of STABLE_CYCLES-1 samples: count completes as the pattern changes.
        q_s = 4'b1101;
        repeat (3) step();
        q_s = 4'b1111;
        count_valid(15, cnt);
        check("short_glitch", cnt, 0);

        // Enable high blocks capture.
        e_s = 1'b1;
        q_s = 4'b1101;
        ready_s = 1'b0;
        count_valid(12, cnt);
        check("enable_block", cnt, 0);
        e_s = 1'b0;
        wait_valid(10, n);
        check("enable_capture", int'(n != 0), 1);

        // Backpressure: code held while Q and E wander.
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            q_s = 4'(i);
            e_s = 1'(i % 2);
            step();
            if (!valid_s || ({a_s, b_s} != 2'b10) || multi_s) bad++;
        end
        check("backpressure_hold", bad, 0);
        q_s = 4'b1101;
        e_s = 1'b0;
        ready_s = 1'b1;
        step();
        check("backpressure_drop", int'(valid_s), 0);
        release_lines();

        // Reset mid-HOLD: code lost, held line needs a fresh debounce.
        ready_s = 1'b0;
        q_s = 4'b1100;
        wait_valid(12, n);
        check("pre_reset_valid", n, 6);
        check("pre_reset_ab", int'({a_s, b_s, multi_s}), 5);
        rst_s = 1'b1;
        step();
        rst_s = 1'b0;
        check("mid_reset_valid", int'(valid_s), 0);
        check("mid_reset_abm", int'({a_s, b_s, multi_s}), 0);
        wait_valid(12, n);
        check("post_reset_latency", n, 6);
        check("post_reset_ab", int'({a_s, b_s, multi_s}), 5);
        ready_s = 1'b1;
        step();
        check("post_reset_drop", int'(valid_s), 0);
        release_lines();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/encoder_4x2_sync.md
Name: encoder_4x2_sync

Overview:
- Clocked 4-to-2 priority encoder with active-low line inputs; the inverse of the team's 2x4 active-low decoders.
- Synchronises and debounces four active-low request lines, encodes the winning line to {A,B}, and presents the code on a valid/ready handshake.
- Sits between external request lines (push-buttons, interrupt strobes) and a consumer FSM.
- Line mapping matches the behavioural decoder: code 00 ↔ Q[3]=0, 01 ↔ Q[2]=0, 10 ↔ Q[1]=0, 11 ↔ Q[0]=0.

Parameters:
- STABLE_CYCLES, 4: consecutive identical synchronised samples required before a pattern is accepted. Legal range 2..255; elaboration error outside it.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- Q  input  [3:0]  active-low request lines, asynchronous to clk.
- E  input  1  active-low enable; 1 blocks new captures.
- A  output  1  code MSB.
- B  output  1  code LSB.
- valid  output  1  {A,B,multi} hold an accepted code.
- ready  input  1  consumer accepts the code when valid && ready.
- multi  output  1  more than one line was low in the accepted pattern.

Behaviour:
- Reset: with rst=1 at an edge, the following are cleared:
  - state=IDLE, A=0, B=0, valid=0, multi=0, counter=0.
  - Both synchroniser stages are set to 4'b1111.
  - Reset asserted mid-operation discards any pending code; valid falls after that edge.
- Synchroniser: two flops on Q give q_s. E is sampled directly, since it is a synchronous input.
- FSM states: IDLE, DEBOUNCE, HOLD, RELEASE.
- IDLE:
  - If E=0 and q_s!=4'b1111: pat<=q_s, cnt<=1, go to DEBOUNCE.
  - Otherwise stay.
- DEBOUNCE:
  - If E=1 or q_s!=pat: go to IDLE, cnt<=0. A bounce restarts the debounce, and the next IDLE cycle may re-capture.
  - Else if cnt==STABLE_CYCLES-1: go to HOLD and latch outputs:
    - {A,B} <= priority code of pat; the lowest code wins (Q[3] highest priority).
    - multi <= (number of zero bits in pat > 1).
    - valid<=1.
  - Else cnt<=cnt+1.
- HOLD:
  - valid=1; A, B and multi are stable.
  - On valid && ready at an edge: valid<=0, go to RELEASE.
  - E and Q changes are ignored in HOLD; the code is never dropped.
- RELEASE:
  - Wait until q_s==4'b1111, then go to IDLE.
  - A held line produces exactly one code; no auto-repeat.
  - A and B keep their last values (don't-care to the consumer).
- Latency: Q stable from before edge 1 → valid=1 after edge STABLE_CYCLES+2 (edge 6 at default).
- Backpressure: ready may be held low indefinitely; when ready=1 already at HOLD entry, the handshake completes on the next edge (valid high for one cycle).
- Simultaneous events:
  - Pattern change and debounce completion on the same edge → mismatch wins; go to IDLE.
  - ready while not valid is ignored.
- Counter width: $clog2(STABLE_CYCLES+1) bits; no wrap is possible because of the terminal compare.

Decomposition:
- Package encoder_pkg holds:
  - typedef enum logic [1:0] {IDLE, DEBOUNCE, HOLD, RELEASE} enc_state_t.
  - function prio_encode(logic [3:0] pat) returning logic [1:0].
  - function multi_low(logic [3:0]) returning logic.
  - localparam LINES_IDLE = 4'b1111.
- One sub-module: sync_2ff #(W=4), a two-flop synchroniser with synchronous reset to all-ones.

Test Plan:
- Single line: Q=4'b0111 held, ready=1 → valid pulses one cycle after edge 6; A=0, B=0, multi=0; no second valid until Q returns to 4'b1111.
- All codes:
  - Q=1011 → AB=01.
  - Q=1101 → AB=10.
  - Q=1110 → AB=11.
  - Release each line between codes; multi=0 throughout.
- Priority: Q=4'b1010 stable → AB=01, multi=1. Q=4'b0000 → AB=00, multi=1.
- Bounce: Q=1110 for 2 cycles, then 1111 for 1 cycle, then 1110 stable → exactly one valid, 6 edges after the final stable start; glitches shorter than STABLE_CYCLES yield no valid.
- Enable and backpressure:
  - E=1 with Q=1101 → no valid.
  - E=0 → capture occurs.
  - ready=0 for 20 cycles → valid and AB=10 held constant, even if Q and E change meanwhile.
  - ready=1 → valid drops after one edge.
- Reset mid-HOLD: rst=1 for one edge while valid=1 → valid=0, A=B=multi=0 next cycle; the event is lost, and a still-held line is re-captured only after a fresh debounce.
